// File: rtl/prog_lut_sweep.sv
// Loadable-truth-table Boolean function with a self-checking sweep mode:
// steps every input index, holds each HOLD cycles, captures and scores the results.
module prog_lut_sweep #(
  parameter int N_IN = 3,
  parameter int HOLD = 4,
  parameter logic [(1<<N_IN)-1:0] INIT = 'hCE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_we,
  input  logic [(1<<N_IN)-1:0]  i_cfg_data,
  input  logic [N_IN-1:0]       i_in_vec,
  input  logic                  i_sweep_start,
  input  logic [(1<<N_IN)-1:0]  i_exp_vec,
  output logic                  o_f,
  output logic                  o_busy,
  output logic [N_IN-1:0]       o_cur_idx,
  output logic                  o_done,
  output logic [(1<<N_IN)-1:0]  o_sweep_vec,
  output logic [N_IN:0]         o_ones_cnt,
  output logic                  o_pass
);
  localparam int W    = 1 << N_IN;
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  logic [W-1:0]    r_table;
  logic [HC_W-1:0] r_hold;
  logic [N_IN-1:0] r_cur_idx;
  logic [W-1:0]    r_sweep_vec;
  logic [N_IN:0]   r_ones_cnt;
  logic            r_f, r_busy, r_done, r_pass;

  logic [N_IN-1:0] w_sel;
  logic            w_cap_bit;
  logic [W-1:0]    w_next_vec;

  assign w_sel     = (r_state == RUN) ? r_cur_idx : i_in_vec;
  assign w_cap_bit = r_table[r_cur_idx];

  // Result vector including the bit captured this cycle, so the final compare sees it.
  always_comb begin
    w_next_vec = r_sweep_vec;
    w_next_vec[r_cur_idx] = w_cap_bit;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_table     <= INIT;
      r_hold      <= '0;
      r_cur_idx   <= '0;
      r_sweep_vec <= '0;
      r_ones_cnt  <= '0;
      r_f         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_f    <= r_table[w_sel];
      case (r_state)
        IDLE: begin
          if (i_cfg_we) r_table <= i_cfg_data;
          if (i_sweep_start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_hold      <= '0;
            r_cur_idx   <= '0;
            r_sweep_vec <= '0;
            r_ones_cnt  <= '0;
            r_pass      <= 1'b0;
          end
        end
        RUN: begin
          if (r_hold != HC_W'(HOLD - 1)) begin
            r_hold <= r_hold + HC_W'(1);
          end else begin
            r_hold      <= '0;
            r_sweep_vec <= w_next_vec;
            r_ones_cnt  <= r_ones_cnt + (N_IN+1)'(w_cap_bit);
            if (r_cur_idx != N_IN'(W - 1)) begin
              r_cur_idx <= r_cur_idx + N_IN'(1);
            end else begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= (w_next_vec == i_exp_vec);
              r_cur_idx <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_f         = r_f;
  assign o_busy      = r_busy;
  assign o_cur_idx   = r_cur_idx;
  assign o_done      = r_done;
  assign o_sweep_vec = r_sweep_vec;
  assign o_ones_cnt  = r_ones_cnt;
  assign o_pass      = r_pass;
endmodule
